// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: registered request side plus one-cycle ack/rdata return.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues aligned loads/stores to data memory, stalls upstream while waiting,
// extracts/extends load lanes and produces the MEM/WB payload; faults on misalignment or timeout.
module mem_access_stage #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [31:0]                ex_alu_result,
    input  logic [31:0]                ex_store_data,
    input  logic [4:0]                 ex_rd,
    input  logic                       ex_mem_read,
    input  logic                       ex_mem_write,
    input  logic                       ex_reg_write,
    input  logic [1:0]                 ex_size,
    input  logic                       ex_unsigned,
    mem_access_stage_if.master         dmem,
    output logic                       stall,
    output logic                       wb_valid,
    output logic                       wb_reg_write,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic                       fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lane_q, lane_d, size_q, size_d;
    logic        uns_q, uns_d, regw_q, regw_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d, fault_q, fault_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    // Set on timeout abort: the aborted instruction is still on the EX/MEM inputs for one more cycle.
    logic        drop_q, drop_d;

    logic        is_mem_c, legal_c, start_c;
    logic [31:0] lane_data_c, load_ext_c;

    // Request classification of the instruction currently in EX/MEM
    always_comb begin
        is_mem_c = ex_mem_read || ex_mem_write;
        legal_c  = 1'b1;
        unique case (ex_size)
            SZ_BYTE: legal_c = 1'b1;
            SZ_HALF: legal_c = ~ex_alu_result[0];
            SZ_WORD: legal_c = (ex_alu_result[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
        start_c = rst && (state_q == IDLE) && !drop_q && ex_valid && is_mem_c && legal_c;
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        lane_data_c = dmem.rdata >> {lane_q, 3'b000};
        unique case (size_q)
            SZ_BYTE: load_ext_c = uns_q ? {24'h0, lane_data_c[7:0]}
                                        : {{24{lane_data_c[7]}}, lane_data_c[7:0]};
            SZ_HALF: load_ext_c = uns_q ? {16'h0, lane_data_c[15:0]}
                                        : {{16{lane_data_c[15]}}, lane_data_c[15:0]};
            default: load_ext_c = dmem.rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        lane_d     = lane_q;
        size_d     = size_q;
        uns_d      = uns_q;
        regw_d     = regw_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_regw_d  = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        drop_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && !drop_q) begin
                    if (!is_mem_c) begin
                        wb_valid_d = 1'b1;
                        wb_regw_d  = ex_reg_write;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu_result;
                    end else if (!legal_c) begin
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = 32'h0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = ex_mem_write;
                        addr_d  = {ex_alu_result[31:2], 2'b00};
                        lane_d  = ex_alu_result[1:0];
                        size_d  = ex_size;
                        uns_d   = ex_unsigned;
                        regw_d  = ex_reg_write;
                        rd_d    = ex_rd;
                        unique case (ex_size)
                            SZ_BYTE: begin
                                be_d    = 4'b0001 << ex_alu_result[1:0];
                                wdata_d = {4{ex_store_data[7:0]}};
                            end
                            SZ_HALF: begin
                                be_d    = 4'b0011 << ex_alu_result[1:0];
                                wdata_d = {2{ex_store_data[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = ex_store_data;
                            end
                        endcase
                    end
                end
            end
            ACCESS: begin
                if (dmem.ack) begin
                    state_d    = DONE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_regw_d  = regw_q && !we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = we_q ? 32'h0 : load_ext_c;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = 32'h0;
                    drop_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            regw_q     <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            fault_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            regw_q     <= regw_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_regw_q  <= wb_regw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
            drop_q     <= drop_d;
        end
    end

    // Stall covers the entry cycle combinationally, then every ACCESS cycle
    assign stall        = start_c || (rst && state_q == ACCESS);
    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.wdata   = wdata_q;
    assign dmem.be      = be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_regw_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: reference model pushes expected MEM/WB results and
// memory requests at issue time; a negedge monitor with a simple memory responder pops and compares.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_unsigned;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_size;
    logic        stall, wb_valid, wb_reg_write, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT(8'd64)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .dmem(dmem.master), .stall(stall), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [4:0] rd; logic rw; logic flt; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } rq_t;

    wb_t wb_q[$];
    rq_t rq_q[$];
    rq_t cur_rq;

    int          n_total = 0;
    int          n_bad   = 0;
    int          stall_cnt, req_total, req_cyc, ack_delay;
    logic        mon_en = 1'b0;
    logic        spur = 1'b0;
    logic        ack_given = 1'b0;
    logic [31:0] mem_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor, scoreboard compare and memory responder
    always @(negedge clk) begin
        wb_t e;
        if (mon_en) begin
            if (stall) stall_cnt++;
            if (wb_valid) begin
                if (wb_q.size() == 0) check("wb_extra", 32'(wb_valid), 32'd0);
                else begin
                    e = wb_q.pop_front();
                    check("wb_data", wb_data, e.data);
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_rw", 32'(wb_reg_write), 32'(e.rw));
                    check("wb_fault", 32'(fault), 32'(e.flt));
                end
            end else if (fault) check("fault_stray", 32'(fault), 32'd0);
            if (ack_given) check("ack_latency", 32'(wb_valid), 32'd1);
            if (ack_given && dmem.req) check("req_after_ack", 32'(dmem.req), 32'd0);
            if (dmem.req) begin
                if (req_cyc == 0) begin
                    if (rq_q.size() == 0) begin
                        check("req_extra", 32'(dmem.req), 32'd0);
                        cur_rq = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
                    end else cur_rq = rq_q.pop_front();
                end
                check("req_we", 32'(dmem.we), 32'(cur_rq.we));
                check("req_addr", dmem.addr, cur_rq.addr);
                check("req_be", 32'(dmem.be), 32'(cur_rq.be));
                check("req_wdata", dmem.wdata, cur_rq.wdata);
                req_cyc++;
                req_total++;
            end else req_cyc = 0;
        end
        dmem.ack   = (mon_en && dmem.req && ack_delay != 0 && req_cyc == ack_delay) || spur;
        dmem.rdata = mem_rdata;
        ack_given  = mon_en && dmem.ack && dmem.req;
    end

    // Reference model: expected request and MEM/WB result for one instruction
    task automatic model(input logic rd_en, wr_en, rw, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, sd, input logic [4:0] rd);
        logic        legal;
        logic [1:0]  ln;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        rq_t         r;
        ln    = a[1:0];
        legal = (size == 2'b00) || (size == 2'b01 && !a[0]) || (size == 2'b10 && a[1:0] == 2'b00);
        if (!rd_en && !wr_en) wb_q.push_back('{data: a, rd: rd, rw: rw, flt: 1'b0});
        else if (!legal) wb_q.push_back('{data: 32'h0, rd: rd, rw: 1'b0, flt: 1'b1});
        else begin
            r.we   = wr_en;
            r.addr = a & 32'hFFFF_FFFC;
            case (size)
                2'b00:   begin r.be = 4'(1 << ln); r.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; end
                2'b01:   begin r.be = 4'(3 << ln); r.wdata = {sd[15:0], sd[15:0]}; end
                default: begin r.be = 4'hF; r.wdata = sd; end
            endcase
            rq_q.push_back(r);
            b = mem_rdata[8*ln +: 8];
            h = mem_rdata[8*ln +: 16];
            case (size)
                2'b00:   ld = uns ? 32'(b) : 32'($signed(b));
                2'b01:   ld = uns ? 32'(h) : 32'($signed(h));
                default: ld = mem_rdata;
            endcase
            if (ack_delay == 0 || ack_delay > 64) wb_q.push_back('{data: 32'h0, rd: rd, rw: 1'b0, flt: 1'b1});
            else if (wr_en) wb_q.push_back('{data: 32'h0, rd: rd, rw: 1'b0, flt: 1'b0});
            else wb_q.push_back('{data: ld, rd: rd, rw: rw, flt: 1'b0});
        end
    endtask

    // Present one instruction and hold it until the stage accepts it (stall low at an edge)
    task automatic issue(input logic rd_en, wr_en, rw, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, sd, input logic [4:0] rd);
        logic st;
        int   guard;
        model(rd_en, wr_en, rw, size, uns, a, sd, rd);
        ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_reg_write = rw;
        ex_size = size; ex_unsigned = uns; ex_alu_result = a; ex_store_data = sd; ex_rd = rd;
        guard = 0;
        forever begin
            @(negedge clk);
            st = stall;
            @(posedge clk);
            #1;
            if (!st) break;
            guard++;
            if (guard > 200) begin
                check("stall_bound", 32'(st), 32'd0);
                break;
            end
        end
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_size = 2'b00; ex_unsigned = 1'b0; ex_alu_result = 32'h0; ex_store_data = 32'h0;
        ex_rd = 5'd0; ack_delay = 1; mem_rdata = 32'h0;
        stall_cnt = 0; req_total = 0; req_cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem.req), 32'd0);
        check("rst_be", 32'(dmem.be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // ALU pass-through
        stall_cnt = 0;
        issue(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5);
        idle(3);
        check("alu_stall_cycles", 32'(stall_cnt), 32'd0);

        // Signed byte load, ack in third access cycle
        ack_delay = 3; mem_rdata = 32'h80AA_BBCC; stall_cnt = 0;
        issue(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd7);
        idle(3);
        check("lb_stall_cycles", 32'(stall_cnt), 32'd4);

        // Half store
        ack_delay = 2;
        issue(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 5'd3);
        idle(3);

        // Misaligned word load: fault, no request
        req_total = 0;
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd4);
        idle(3);
        check("misalign_no_req", 32'(req_total), 32'd0);

        // Timeout with no ack
        ack_delay = 0; req_total = 0; stall_cnt = 0;
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd9);
        idle(3);
        check("timeout_req_cycles", 32'(req_total), 32'd64);
        check("timeout_stall_cycles", 32'(stall_cnt), 32'd65);

        // Ack while idle is ignored
        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(3);

        // Random mix, back-to-back
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            ack_delay = int'($urandom_range(1, 4));
            mem_rdata = $urandom;
            op = 2'($urandom_range(0, 2));
            issue(op == 2'd1, op == 2'd2, 1'($urandom), 2'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(4);

        // Reset in the middle of an access, then a late ack
        ack_delay = 0;
        rq_q.push_back('{we: 1'b0, addr: 32'h0000_0080, wdata: 32'h5555_AAAA, be: 4'hF});
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
        ex_size = 2'b10; ex_alu_result = 32'h0000_0080; ex_store_data = 32'h5555_AAAA; ex_rd = 5'd11;
        idle(5);
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        ex_valid = 1'b0;
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(dmem.req), 32'd0);
        check("midrst_addr", dmem.addr, 32'd0);
        check("midrst_wdata", dmem.wdata, 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(4);

        check("wb_left", 32'(wb_q.size()), 32'd0);
        check("req_left", 32'(rq_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
